// File: rtl/move_input_conditioner.sv
// move_input_conditioner: turns four raw direction buttons into synchronised, debounced, single-cycle move pulses.
// Define MOVE_AUTOREPEAT_EN to re-issue a held move every REPEAT_CYCLES.
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 25_000_000,
  parameter int CNT_W           = 25
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnU,
  input  logic BtnD,
  input  logic BtnL,
  input  logic BtnR,
  input  logic accept,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic pending,
  output logic q_Idle,
  output logic q_Debounce,
  output logic q_Armed,
  output logic q_Release
);
  localparam logic [3:0] IDLE     = 4'b0001;
  localparam logic [3:0] DEBOUNCE = 4'b0010;
  localparam logic [3:0] ARMED    = 4'b0100;
  localparam logic [3:0] RELEASE  = 4'b1000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  logic [3:0] sync1_q, sync1_d, sync2_q, sync2_d, s;
  logic [3:0] state_q, state_d;
  logic [3:0] pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] dir_q, dir_d, prio;
  logic pending_q, pending_d;
  logic s_dir, any_s, cnt_last;
`ifdef MOVE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
`else
  if (REPEAT_CYCLES < 2) begin : g_repeat_unused
  end
`endif
  assign sync1_d  = {BtnR, BtnL, BtnD, BtnU};
  assign sync2_d  = sync1_q;
  assign s        = sync2_q;
  assign s_dir    = s[dir_q];
  assign any_s    = |s;
  assign cnt_last = cnt_q == CNT_LAST;
  assign prio     = s[0] ? 2'd0 : s[1] ? 2'd1 : s[2] ? 2'd2 : 2'd3;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    pending_d = pending_q;
    pulse_d   = '0;
`ifdef MOVE_AUTOREPEAT_EN
    rcnt_d    = rcnt_q;
`endif
    case (state_q)
      IDLE: if (any_s) begin
        dir_d   = prio;
        cnt_d   = '0;
        state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        cnt_d     = cnt_q + CNT_ONE;
        state_d   = !s_dir ? IDLE : cnt_last ? ARMED : DEBOUNCE;
        pending_d = s_dir && cnt_last;
      end
      ARMED: if (accept) begin
        pulse_d   = 4'b0001 << dir_q;
        pending_d = 1'b0;
        cnt_d     = '0;
        state_d   = RELEASE;
`ifdef MOVE_AUTOREPEAT_EN
        rcnt_d    = '0;
`endif
      end
      RELEASE: begin
        // Any button activity restarts the release window, not just the issued direction.
        cnt_d   = any_s ? '0 : cnt_q + CNT_ONE;
        state_d = (!any_s && cnt_last) ? IDLE : RELEASE;
`ifdef MOVE_AUTOREPEAT_EN
        rcnt_d = s_dir ? rcnt_q + CNT_ONE : '0;
        if (s_dir && rcnt_q == RPT_LAST) begin
          state_d   = ARMED;
          pending_d = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= IDLE;
      pulse_q   <= '0;
      cnt_q     <= '0;
      dir_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
    end
  end
`ifdef MOVE_AUTOREPEAT_EN
  always_ff @(posedge Clk) begin
    if (Reset) rcnt_q <= '0;
    else rcnt_q <= rcnt_d;
  end
`endif
  assign {right, left, down, up} = pulse_q;
  assign pending = pending_q;
  assign {q_Release, q_Armed, q_Debounce, q_Idle} = state_q;
endmodule

// File: tb/tb_move_input_conditioner.sv
// tb_move_input_conditioner: directed scenarios plus random button traffic checked against a behavioural model.
module tb_move_input_conditioner;
  localparam int D = 4;
  localparam int R = 10;
  logic Clk = 1'b0, Reset = 1'b1, accept = 1'b0;
  logic BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
  logic up, down, left, right, pending, q_Idle, q_Debounce, q_Armed, q_Release;
  int errors = 0, checks = 0;
  int n_up, n_down, n_left, n_right, stepno;
  int up_at[$];
  always #5 Clk = ~Clk;

  move_input_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .CNT_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .accept(accept), .up(up), .down(down), .left(left), .right(right), .pending(pending),
    .q_Idle(q_Idle), .q_Debounce(q_Debounce), .q_Armed(q_Armed), .q_Release(q_Release));

  // Reference: raw levels seen one and two edges ago, phase 0..3 = idle/debounce/armed/release,
  // and how many consecutive qualifying edges have been seen in the current phase.
  logic [3:0] m_h1 = '0, m_h2 = '0, m_pulse = '0;
  int m_ph = 0, m_dir = 0, m_run = 0, m_rrun = 0;
  logic m_pend = 1'b0;

  function automatic int first_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input logic [3:0] raw, input logic rst, input logic acc);
    logic [3:0] s;
    s = m_h2;
    m_pulse = '0;
    if (rst) begin
      m_h1 = '0; m_h2 = '0; m_ph = 0; m_dir = 0; m_run = 0; m_rrun = 0; m_pend = 1'b0;
      return;
    end
    if (m_ph == 0) begin
      if (s != 0) begin m_dir = first_set(s); m_run = 0; m_ph = 1; end
    end else if (m_ph == 1) begin
      if (!s[m_dir]) m_ph = 0;
      else if (m_run + 1 == D) begin m_ph = 2; m_pend = 1'b1; end
      else m_run++;
    end else if (m_ph == 2) begin
      if (acc) begin m_pulse[m_dir] = 1'b1; m_pend = 1'b0; m_run = 0; m_rrun = 0; m_ph = 3; end
    end else begin
      if (s == 0) begin
        if (m_run + 1 == D) m_ph = 0; else m_run++;
      end else m_run = 0;
`ifdef MOVE_AUTOREPEAT_EN
      if (s[m_dir]) begin
        if (m_rrun + 1 == R) begin m_ph = 2; m_pend = 1'b1; end
        m_rrun++;
      end else m_rrun = 0;
`endif
    end
    m_h2 = m_h1;
    m_h1 = raw;
  endtask

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s step %0d: got %h expected %h", tag, stepno, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_tally();
    n_up = 0; n_down = 0; n_left = 0; n_right = 0;
    up_at.delete();
  endtask

  task automatic step(input logic [3:0] btn, input logic rst, input logic acc);
    {BtnR, BtnL, BtnD, BtnU} = btn;
    Reset = rst;
    accept = acc;
    @(posedge Clk);
    model_edge(btn, rst, acc);
    #1;
    stepno++;
    chk("pulses", {right, left, down, up}, m_pulse);
    chk("pending", {3'b0, pending}, {3'b0, m_pend});
    chk("state", {q_Release, q_Armed, q_Debounce, q_Idle}, 4'(1 << m_ph));
    if (up) up_at.push_back(stepno);
    n_up += int'(up); n_down += int'(down); n_left += int'(left); n_right += int'(right);
  endtask

  task automatic repeat_step(input int n, input logic [3:0] btn, input logic acc);
    for (int i = 0; i < n; i++) step(btn, 1'b0, acc);
  endtask

  initial begin
    int lat, len;
    logic [3:0] btn;
    logic rst, acc;
    stepno = 0;
    clear_tally();
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    chk("reset_pulses", {right, left, down, up}, 4'b0000);
    chk("reset_pending", {3'b0, pending}, 4'b0000);
    chk("reset_idle", {q_Release, q_Armed, q_Debounce, q_Idle}, 4'b0001);

    // Clean press: pulse after the (D+4)th edge following the press, then hold.
    clear_tally();
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      step(4'b0001, 1'b0, 1'b1);
      if (up && lat < 0) lat = k;
    end
    chk_int("press_latency", lat, D + 4);
`ifdef MOVE_AUTOREPEAT_EN
    chk_int("repeat_count", up_at.size(), 4);
    for (int i = 1; i < up_at.size(); i++) chk_int("repeat_period", up_at[i] - up_at[i-1], R + 1);
`else
    chk_int("held_single_up", n_up, 1);
`endif
    chk_int("press_others", n_down + n_left + n_right, 0);
    repeat_step(14, 4'b0000, 1'b1);

    // Bounce: 3-cycle glitch must not produce a move, steady press gives one.
    clear_tally();
    repeat_step(3, 4'b0100, 1'b1);
    repeat_step(3, 4'b0000, 1'b1);
    repeat_step(12, 4'b0100, 1'b1);
    repeat_step(12, 4'b0000, 1'b1);
    chk_int("bounce_left", n_left, 1);
    chk_int("bounce_others", n_up + n_down + n_right, 0);

    // Held-off accept: move stays latched after the button is released.
    clear_tally();
    repeat_step(12, 4'b1000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(4'b0000, 1'b0, 1'b0);
      chk("held_pending", {3'b0, pending}, 4'b0001);
      chk("held_armed", {3'b0, q_Armed}, 4'b0001);
    end
    chk_int("held_no_pulse", n_right, 0);
    step(4'b0000, 1'b0, 1'b1);
    chk("held_right", {3'b0, right}, 4'b0001);
    step(4'b0000, 1'b0, 1'b0);
    chk("held_pending_clr", {3'b0, pending}, 4'b0000);
    chk("held_right_once", {3'b0, right}, 4'b0000);
    repeat_step(8, 4'b0000, 1'b1);

    // Simultaneous press: down beats left; left works after a full release.
    clear_tally();
    repeat_step(12, 4'b0110, 1'b1);
    repeat_step(12, 4'b0000, 1'b1);
    chk_int("simul_down", n_down, 1);
    chk_int("simul_left_ignored", n_left, 0);
    repeat_step(12, 4'b0100, 1'b1);
    repeat_step(12, 4'b0000, 1'b1);
    chk_int("simul_left_after", n_left, 1);

    // Reset in the middle of debounce discards the move.
    clear_tally();
    repeat_step(5, 4'b0001, 1'b1);
    chk("mid_debounce", {3'b0, q_Debounce}, 4'b0001);
    step(4'b0000, 1'b1, 1'b1);
    chk("mid_reset_idle", {3'b0, q_Idle}, 4'b0001);
    repeat_step(15, 4'b0000, 1'b1);
    chk_int("mid_reset_no_pulse", n_up + n_down + n_left + n_right, 0);

    // Random traffic against the model.
    for (int n = 0; n < 900;) begin
      btn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) btn = 4'b0000;
      len = $urandom_range(1, 12);
      for (int j = 0; j < len && n < 900; j++) begin
        rst = $urandom_range(0, 149) == 0;
        acc = $urandom_range(0, 9) < 7;
        step(btn, rst, acc);
        n++;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/move_input_conditioner.md
# move_input_conditioner

Converts the four raw, bouncing direction push-buttons into clean, single-cycle move pulses (`up`, `down`, `left`, `right`) for the 2048 game controller. It sits directly upstream of the game state machine. Each press is synchronised and debounced, then resolved to one direction by fixed priority. The move is held pending until the controller signals it can take one, then issued as a one-cycle pulse, so every physical press yields exactly one move.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a level must be stable (10 ms at 100 MHz); legal range ≥ 2.
- `REPEAT_CYCLES`, default 25_000_000: auto-repeat period (used only with `MOVE_AUTOREPEAT_EN`); legal range ≥ 2.
- `CNT_W`, default 25: counter width; must hold `max(DEBOUNCE_CYCLES, REPEAT_CYCLES)`.
- `Clk` in 1: single system clock; everything is on its rising edge.
- `Reset` in 1: synchronous, active-high.
- `BtnU`, `BtnD`, `BtnL`, `BtnR` in 1 each: raw asynchronous buttons, active-high.
- `accept` in 1: controller is ready for a move (tied to the controller's wait-state flag).
- `up`, `down`, `left`, `right` out 1 each: one-hot, single-cycle move pulses; all registered.
- `pending` out 1: a debounced move is latched but not yet issued.
- `q_Idle`, `q_Debounce`, `q_Armed`, `q_Release` out 1 each: one-hot state flags.

## Operation
- **Synchroniser.** Each button passes through a 2-flop synchroniser. Only the synchronised levels (`s*`) are used anywhere else in the block.
- **Direction register.** `dir` is a 2-bit register. When several buttons are high, priority is U > D > L > R.
- **IDLE**
  - Any `s*` high: latch the highest-priority button into `dir`, set `cnt` = 0, go to DEBOUNCE.
- **DEBOUNCE**
  - `s[dir]` low: return to IDLE; no move is produced.
  - `s[dir]` high and `cnt` == `DEBOUNCE_CYCLES`−1: go to ARMED and set `pending` = 1.
  - Otherwise increment `cnt`.
  - Other buttons are ignored in this state.
- **ARMED**
  - `accept` = 1: on the next edge, assert the pulse for `dir` for exactly one cycle, clear `pending`, set `cnt` = 0, go to RELEASE.
  - `accept` = 0: stay in ARMED indefinitely. Releasing the button does not cancel the latched move.
- **RELEASE**
  - All four `s*` low: if `cnt` == `DEBOUNCE_CYCLES`−1, go to IDLE; otherwise increment `cnt`.
  - Any `s*` high: reset `cnt` to 0.
  - No new move can be produced until the buttons have been released and IDLE is re-entered.
- **Pulse outputs.** At most one of `up`/`down`/`left`/`right` is high in any cycle, and never two cycles in a row.
- **Reset** (at any time, including mid-debounce or while pulsing):
  - state = IDLE;
  - `cnt`, `dir`, synchroniser flops = 0;
  - all pulse outputs = 0, `pending` = 0;
  - `q_Idle` = 1, all other state flags = 0.
  - An in-progress move is discarded.

## Timing
- **Press latency.** A clean press made stable before edge 0, with `accept` held at 1, gives a pulse that is high during the cycle after edge `DEBOUNCE_CYCLES`+4. This breaks down as 2 synchroniser edges, 1 capture edge, `DEBOUNCE_CYCLES` count edges and 1 issue edge.
- **Arming.** `pending` goes high on the same edge ARMED is entered.
- **`accept` sampling.** `accept` is sampled at the edge; it does not need to be held after the pulse.
- **Re-arm time.** After the pulse, the buttons must be continuously released for `DEBOUNCE_CYCLES` edges before IDLE is re-entered.
- **Simultaneous press.** When two buttons reach sync in the same cycle, the priority winner is issued and the other is ignored until the release cycle completes.

## Configuration
- `MOVE_AUTOREPEAT_EN` defined:
  - In RELEASE, while `s[dir]` stays high, a second counter `rcnt` counts up.
  - At `rcnt` == `REPEAT_CYCLES`−1, go to ARMED with `pending` = 1; the move is re-issued under the normal `accept` rule.
  - `rcnt` clears on entry to RELEASE and whenever `s[dir]` is low.
- `MOVE_AUTOREPEAT_EN` undefined:
  - `rcnt` and `REPEAT_CYCLES` logic are not compiled.
  - A held button gives exactly one pulse.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and `REPEAT_CYCLES` = 10.
- **Reset values:** assert `Reset` for 2 cycles → all pulse outputs 0, `pending` 0, `q_Idle` 1.
- **Clean press:** `BtnU` held high from edge 0, `accept` = 1 → `up` high for exactly one cycle, after edge 8; `down`/`left`/`right` stay 0. `BtnU` is then held 30 cycles with the macro off → no second pulse.
- **Bounce:** `BtnL` high for 3 cycles, low, then high steadily → no pulse from the glitch; exactly one `left` pulse after the steady press.
- **Held-off accept:** `BtnR` press with `accept` = 0 for 20 cycles and the button released → `pending` = 1 and `q_Armed` = 1 throughout; raising `accept` → one `right` pulse on the next edge, then `pending` = 0.
- **Simultaneous press:** `BtnD` and `BtnL` rise in the same cycle → only `down` pulses. Releasing both for 4+ cycles and then pressing `BtnL` → `left` pulses.
- **Reset mid-operation / auto-repeat:**
  - `Reset` pulsed during DEBOUNCE (`cnt` = 2) → no pulse, `q_Idle` = 1.
  - With `MOVE_AUTOREPEAT_EN` and `BtnU` held → `up` pulses repeat every 11 cycles while `accept` = 1.
